gate_test_sequencer: RTL and testbench

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

---
 rtl/gate_test_sequencer.sv | 156 +++++++++++++++
 tb/tb_gate_test_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// Gate test sequencer: walks every input vector of a small combinational gate,
// holds each one for a settle time, samples the gate output and records which
// vectors disagree with the expected truth table.
module gate_test_sequencer #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [(1<<N_IN)-1:0]   truth_table,
    input  logic                   dut_y,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   mismatch,
    output logic [N_IN-1:0]        vec_idx
);

    localparam int NV = 1 << N_IN;
    // Index of the final vector; all ones for an N_IN-bit index.
    localparam logic [N_IN-1:0] LAST_IDX = '1;
    // APPLY counts down from this value to zero, giving SETTLE_CYCLES cycles.
    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [NV-1:0]     r_tt;
    logic [NV-1:0]     w_tt_next;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_next;
    logic [N_IN-1:0]   r_vec_idx;
    logic [N_IN-1:0]   w_vec_idx_next;
    logic [N_IN-1:0]   r_dut_in;
    logic [N_IN-1:0]   w_dut_in_next;
    logic              r_busy;
    logic              w_busy_next;
    logic              r_done;
    logic              w_done_next;
    logic              r_pass;
    logic              w_pass_next;
    logic [NV-1:0]     r_mismatch;
    logic [NV-1:0]     w_mismatch_next;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_next    = r_state;
        w_tt_next       = r_tt;
        w_cnt_next      = r_cnt;
        w_vec_idx_next  = r_vec_idx;
        w_dut_in_next   = r_dut_in;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_pass_next     = r_pass;
        w_mismatch_next = r_mismatch;

        if (abort && (r_state != S_IDLE)) begin
            // Abort drops the run; mismatch bits gathered so far are kept.
            w_state_next   = S_IDLE;
            w_busy_next    = 1'b0;
            w_dut_in_next  = '0;
            w_vec_idx_next = '0;
            w_pass_next    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        w_tt_next       = truth_table;
                        w_mismatch_next = '0;
                        w_pass_next     = 1'b0;
                        w_vec_idx_next  = '0;
                        w_dut_in_next   = '0;
                        w_cnt_next      = CNT_LOAD;
                        w_busy_next     = 1'b1;
                        w_state_next    = S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (r_cnt == 8'd0) begin
                        w_state_next = S_SAMPLE;
                    end else begin
                        w_cnt_next = r_cnt - 8'd1;
                    end
                end
                S_SAMPLE: begin
                    // dut_y is only looked at here, after the vector has settled.
                    if (dut_y != r_tt[r_vec_idx]) begin
                        w_mismatch_next[r_vec_idx] = 1'b1;
                    end
                    if (r_vec_idx != LAST_IDX) begin
                        w_vec_idx_next = r_vec_idx + 1'b1;
                        w_dut_in_next  = r_vec_idx + 1'b1;
                        w_cnt_next     = CNT_LOAD;
                        w_state_next   = S_APPLY;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    // r_mismatch already holds the final SAMPLE update here.
                    w_done_next    = 1'b1;
                    w_pass_next    = ~|r_mismatch;
                    w_busy_next    = 1'b0;
                    w_dut_in_next  = '0;
                    w_vec_idx_next = '0;
                    w_state_next   = S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tt       <= '0;
            r_cnt      <= '0;
            r_vec_idx  <= '0;
            r_dut_in   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_mismatch <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tt       <= w_tt_next;
            r_cnt      <= w_cnt_next;
            r_vec_idx  <= w_vec_idx_next;
            r_dut_in   <= w_dut_in_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_pass     <= w_pass_next;
            r_mismatch <= w_mismatch_next;
        end
    end

    assign dut_in   = r_dut_in;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign mismatch = r_mismatch;
    assign vec_idx  = r_vec_idx;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: a default-parameter instance driving
// a selectable 2-input gate, and an N_IN=1/SETTLE_CYCLES=1 instance driving an
// inverter.
module tb_gate_test_sequencer;

    localparam int S  = 4;
    localparam int NV = 4;
    localparam int D  = NV * (S + 1) + 1;   // done cycle after the accepting edge
    localparam int D1 = 2 * (1 + 1) + 1;    // same for the small instance

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] truth_table;
    logic       dut_y;
    logic [1:0] dut_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] mismatch;
    logic [1:0] vec_idx;
    logic [1:0] gate_sel;

    logic       start1;
    logic [1:0] tt1;
    logic       dut_y1;
    logic [0:0] dut_in1;
    logic       busy1;
    logic       done1;
    logic       pass1;
    logic [1:0] mm1;
    logic [0:0] vec_idx1;

    int checks = 0;
    int errors = 0;

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    // Gate under test: 0=AND 1=OR 2=XOR 3=NAND
    always_comb begin
        case (gate_sel)
            2'd0:    dut_y = dut_in[0] & dut_in[1];
            2'd1:    dut_y = dut_in[0] | dut_in[1];
            2'd2:    dut_y = dut_in[0] ^ dut_in[1];
            default: dut_y = ~(dut_in[0] & dut_in[1]);
        endcase
    end

    assign dut_y1 = ~dut_in1[0];

    gate_test_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .truth_table(truth_table), .dut_y(dut_y), .dut_in(dut_in),
        .busy(busy), .done(done), .pass(pass), .mismatch(mismatch), .vec_idx(vec_idx)
    );

    gate_test_sequencer #(.N_IN(1), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort),
        .truth_table(tt1), .dut_y(dut_y1), .dut_in(dut_in1),
        .busy(busy1), .done(done1), .pass(pass1), .mismatch(mm1), .vec_idx(vec_idx1)
    );

    typedef struct {
        logic [1:0] gate;
        logic [3:0] tt;
        logic       exp_pass;
        logic [3:0] exp_mm;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full run; checks done/busy/dut_in/vec_idx every cycle, then results.
    task automatic run_check(input logic [1:0] g, input logic [3:0] tt, input logic ep,
                             input logic [3:0] emm, input bit repulse, input string tag);
        int         ev;
        logic [5:0] e;
        gate_sel    = g;
        truth_table = tt;
        start       = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= D + 3; k++) begin
            if (k < NV * (S + 1))  ev = k / (S + 1);
            else if (k < D)        ev = NV - 1;
            else                   ev = 0;
            e = {(k == D), (k < D), 2'(ev), 2'(ev)};
            chk($sformatf("%s cyc%0d done/busy/dut_in/vec_idx", tag, k),
                32'({done, busy, dut_in, vec_idx}), 32'(e));
            if (repulse && k == 7) start = 1'b1;
            if (repulse && k == 8) begin
                start       = 1'b0;
                truth_table = 4'b1110;
            end
            step();
        end
        $display("run %s: pass=%0b mismatch=%04b", tag, pass, mismatch);
        chk({tag, " pass"}, 32'(pass), 32'(ep));
        chk({tag, " mismatch"}, 32'(mismatch), 32'(emm));
    endtask

    // Counts cycles from the accepting edge until done; -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    initial begin
        int  cyc;
        bit  seen;

        vecs[0] = '{2'd0, 4'b1000, 1'b1, 4'b0000};
        vecs[1] = '{2'd1, 4'b1000, 1'b0, 4'b0110};
        vecs[2] = '{2'd2, 4'b0110, 1'b1, 4'b0000};
        vecs[3] = '{2'd2, 4'b1000, 1'b0, 4'b1110};
        vecs[4] = '{2'd3, 4'b1000, 1'b0, 4'b1111};
        vecs[5] = '{2'd0, 4'b0111, 1'b0, 4'b1111};

        start = 0; abort = 0; truth_table = 4'b1000; gate_sel = 0;
        start1 = 0; tt1 = 2'b01;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        $display("reset: busy=%0b done=%0b dut_in=%0d", busy, done, dut_in);
        chk("reset outputs", 32'({busy, done, pass, mismatch, dut_in, vec_idx}), 32'd0);
        chk("reset outputs n1", 32'({busy1, done1, pass1, mm1, dut_in1, vec_idx1}), 32'd0);
        #20 rst_n = 1'b1;
        step();
        chk("idle after reset", 32'(busy), 32'd0);

        // Table-driven full runs
        for (int i = 0; i < 6; i++) begin
            run_check(vecs[i].gate, vecs[i].tt, vecs[i].exp_pass, vecs[i].exp_mm,
                      1'b0, $sformatf("vec%0d", i));
        end

        // start re-pulse and truth_table change during a run
        run_check(2'd0, 4'b1000, 1'b1, 4'b0000, 1'b1, "repulse");

        // Abort while vector 2 is applied
        gate_sel = 2'd1; truth_table = 4'b1000;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 11; k++) step();
        chk("abort pre vec_idx", 32'(vec_idx), 32'd2);
        abort = 1'b1; step(); abort = 1'b0;
        $display("abort: busy=%0b dut_in=%0d pass=%0b mismatch=%04b", busy, dut_in, pass, mismatch);
        chk("abort busy/dut_in/vec_idx/pass", 32'({busy, dut_in, vec_idx, pass}), 32'd0);
        chk("abort mismatch", 32'(mismatch), 32'b0010);
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done) seen = 1'b1;
            step();
        end
        chk("abort no done", 32'(seen), 32'd0);

        // abort and start together in IDLE: abort wins
        abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
        chk("abort+start busy", 32'(busy), 32'd0);
        step();
        chk("abort+start still idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a run
        gate_sel = 2'd1; truth_table = 4'b1000;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 12; k++) step();
        chk("prereset dut_in", 32'(dut_in), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        $display("midrun reset: busy=%0b dut_in=%0d mismatch=%04b", busy, dut_in, mismatch);
        chk("midrun reset clears", 32'({busy, done, pass, mismatch, dut_in, vec_idx}), 32'd0);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (done || busy) seen = 1'b1;
        end
        chk("reset discards run", 32'(seen), 32'd0);
        run_check(2'd0, 4'b1000, 1'b1, 4'b0000, 1'b0, "after_reset");

        // Back-to-back runs
        gate_sel = 2'd2; truth_table = 4'b0110;
        start = 1'b1; step(); start = 1'b0;
        wait_done(cyc);
        chk("b2b first latency", 32'(cyc), 32'(D));
        chk("b2b first pass", 32'(pass), 32'd1);
        start = 1'b1; step(); start = 1'b0;
        chk("b2b accepted busy", 32'(busy), 32'd1);
        chk("b2b pass cleared", 32'(pass), 32'd0);
        truth_table = 4'b1000;
        wait_done(cyc);
        $display("b2b second: cycles=%0d pass=%0b", cyc, pass);
        chk("b2b second latency", 32'(cyc), 32'(D));
        chk("b2b second pass", 32'(pass), 32'd1);

        // Small instance: inverter, N_IN=1, SETTLE_CYCLES=1
        tt1 = 2'b01; start1 = 1'b1; step(); start1 = 1'b0;
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (done1) begin
                cyc = k;
                break;
            end
        end
        $display("n1 inverter tt=01: cycles=%0d pass=%0b mismatch=%02b", cyc, pass1, mm1);
        chk("n1 latency", 32'(cyc), 32'(D1));
        chk("n1 pass", 32'(pass1), 32'd1);
        chk("n1 mismatch", 32'(mm1), 32'd0);
        tt1 = 2'b10; step(); start1 = 1'b1; step(); start1 = 1'b0;
        for (int k = 1; k <= D1 + 1; k++) step();
        $display("n1 inverter tt=10: pass=%0b mismatch=%02b", pass1, mm1);
        chk("n1 bad pass", 32'(pass1), 32'd0);
        chk("n1 bad mismatch", 32'(mm1), 32'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
